// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: IF/ID pipeline register, IF/EX valid-ready
// handshake, load-use hazard bubble insertion and ID datapath decode
// (immediate format select, source-register use, illegal detection).
module id_stage_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_valid,
  input  logic [31:0]            if_instr,
  input  logic [31:0]            if_pc,
  output logic                   id_ready,
  output logic                   id_valid,
  input  logic                   ex_ready,
  output logic [31:0]            id_instr,
  output logic [31:0]            id_pc,
  output logic [2:0]             imm_sel,
  output logic [4:0]             rs1_addr,
  output logic [4:0]             rs2_addr,
  output logic                   rs1_used,
  output logic                   rs2_used,
  output logic                   id_illegal,
  input  logic                   ex_valid,
  input  logic                   ex_is_load,
  input  logic [4:0]             ex_rd,
  input  logic                   flush,
  output logic [1:0]             id_state,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_STALL = 2'd2
  } id_state_e;

  localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  logic                   valid_r;
  logic [31:0]            instr_r;
  logic [31:0]            pc_r;
  id_state_e              state_r;
  logic [STALL_CNT_W-1:0] stall_cnt_r;

  logic [4:0] opcode_s;
  logic [2:0] imm_sel_s;
  logic       rs1_used_s;
  logic       rs2_used_s;
  logic       illegal_s;
  logic       rs1_match_s;
  logic       rs2_match_s;
  logic       hazard_s;
  logic       capture_s;
  logic       handoff_s;

  assign opcode_s = instr_r[6:2];
  assign rs1_addr = instr_r[19:15];
  assign rs2_addr = instr_r[24:20];

  // Decode the held instruction into immediate format and register-use flags.
  always_comb begin
    imm_sel_s  = IMM_NONE;
    rs1_used_s = 1'b0;
    rs2_used_s = 1'b0;
    illegal_s  = 1'b0;
    if (instr_r[1:0] != 2'b11) begin
      illegal_s = 1'b1;
    end else begin
      case (opcode_s)
        5'b00000, 5'b00100, 5'b11001: begin
          imm_sel_s  = IMM_I;
          rs1_used_s = 1'b1;
        end
        5'b01000: begin
          imm_sel_s  = IMM_S;
          rs1_used_s = 1'b1;
          rs2_used_s = 1'b1;
        end
        5'b11000: begin
          imm_sel_s  = IMM_B;
          rs1_used_s = 1'b1;
          rs2_used_s = 1'b1;
        end
        5'b01101, 5'b00101: begin
          imm_sel_s = IMM_U;
        end
        5'b11011: begin
          imm_sel_s = IMM_J;
        end
        5'b01100: begin
          rs1_used_s = 1'b1;
          rs2_used_s = 1'b1;
        end
        5'b00011, 5'b11100: begin
          rs1_used_s = 1'b1;
        end
        default: begin
          illegal_s = 1'b1;
        end
      endcase
    end
  end

  // A load in EX whose destination feeds a used source of ID forces a bubble;
  // x0 is never a real dependency.
  assign rs1_match_s = rs1_used_s & (rs1_addr == ex_rd);
  assign rs2_match_s = rs2_used_s & (rs2_addr == ex_rd);
  assign hazard_s    = valid_r & ex_valid & ex_is_load & (ex_rd != 5'd0)
                     & (rs1_match_s | rs2_match_s);

  // Handshake is a function of held state, EX and flush only, never if_valid.
  assign id_valid  = valid_r & ~hazard_s & ~flush;
  assign id_ready  = ~flush & (~valid_r | (ex_ready & ~hazard_s));
  assign capture_s = id_ready & if_valid;
  assign handoff_s = id_valid & ex_ready;

  assign id_instr   = instr_r;
  assign id_pc      = pc_r;
  assign id_state   = state_r;
  assign stall_cnt  = stall_cnt_r;
  assign imm_sel    = imm_sel_s;
  assign rs1_used   = rs1_used_s;
  assign rs2_used   = rs2_used_s;
  assign id_illegal = valid_r & illegal_s;

  // IF/ID pipeline register: flush kills, capture loads, handoff empties.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      instr_r <= 32'd0;
      pc_r    <= 32'd0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (capture_s) begin
      valid_r <= 1'b1;
      instr_r <= if_instr;
      pc_r    <= if_pc;
    end else if (handoff_s) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Occupancy FSM tracking EMPTY / FULL / hazard STALL.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_EMPTY;
    end else if (flush) begin
      state_r <= ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (capture_s) state_r <= ST_FULL;
          else           state_r <= ST_EMPTY;
        end
        ST_FULL, ST_STALL: begin
          if (hazard_s)       state_r <= ST_STALL;
          else if (capture_s) state_r <= ST_FULL;
          else if (handoff_s) state_r <= ST_EMPTY;
          else                state_r <= ST_FULL;
        end
        default: begin
          state_r <= ST_EMPTY;
        end
      endcase
    end
  end

  // Saturating count of cycles lost to load-use hazards.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {STALL_CNT_W{1'b0}};
    end else if (hazard_s && !flush && (stall_cnt_r != STALL_MAX)) begin
      stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Table-driven bench for id_stage_ctrl: one row per clock cycle holding the
// inputs for that cycle and the outputs expected before the rising edge.
module tb_id_stage_ctrl;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         if_valid;
  logic [31:0]  if_instr;
  logic [31:0]  if_pc;
  logic         id_ready;
  logic         id_valid;
  logic         ex_ready;
  logic [31:0]  id_instr;
  logic [31:0]  id_pc;
  logic [2:0]   imm_sel;
  logic [4:0]   rs1_addr;
  logic [4:0]   rs2_addr;
  logic         rs1_used;
  logic         rs2_used;
  logic         id_illegal;
  logic         ex_valid;
  logic         ex_is_load;
  logic [4:0]   ex_rd;
  logic         flush;
  logic [1:0]   id_state;
  logic [W-1:0] stall_cnt;

  id_stage_ctrl #(.STALL_CNT_W(W)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .id_ready(id_ready), .id_valid(id_valid),
    .ex_ready(ex_ready), .id_instr(id_instr), .id_pc(id_pc),
    .imm_sel(imm_sel), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .id_illegal(id_illegal),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .flush(flush), .id_state(id_state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_A = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] I_B = 32'h00112023; // sw x1,0(x2)
  localparam logic [31:0] I_C = 32'h00728333; // add x6,x5,x7
  localparam logic [31:0] I_D = 32'h000282B7; // lui x5,0x28 (rs1 field = 5)
  localparam logic [31:0] I_E = 32'h000000EF; // jal x1,0
  localparam logic [31:0] I_F = 32'h00000197; // auipc x3,0
  localparam logic [31:0] I_G = 32'h00208063; // beq x1,x2,0
  localparam logic [31:0] I_H = 32'h00500090; // low bits 00

  typedef struct {
    logic        iv;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        er;
    logic        exv;
    logic        exl;
    logic [4:0]  exrd;
    logic        fl;
    logic        v;
    logic        r;
    logic [1:0]  st;
    logic [2:0]  imm;
    logic        r1u;
    logic        r2u;
    logic        ill;
    logic [W-1:0] cnt;
    logic [31:0] ei;
    logic [31:0] ep;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                     input logic er, input logic exv, input logic exl,
                     input logic [4:0] exrd, input logic fl,
                     input logic v, input logic r, input logic [1:0] st,
                     input logic [2:0] imm, input logic r1u, input logic r2u,
                     input logic ill, input logic [W-1:0] cnt,
                     input logic [31:0] ei, input logic [31:0] ep);
    vec_t t;
    t.iv = iv; t.ins = ins; t.pc = pc; t.er = er; t.exv = exv; t.exl = exl;
    t.exrd = exrd; t.fl = fl; t.v = v; t.r = r; t.st = st; t.imm = imm;
    t.r1u = r1u; t.r2u = r2u; t.ill = ill; t.cnt = cnt; t.ei = ei; t.ep = ep;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    if_valid = t.iv; if_instr = t.ins; if_pc = t.pc; ex_ready = t.er;
    ex_valid = t.exv; ex_is_load = t.exl; ex_rd = t.exrd; flush = t.fl;
  endtask

  task automatic check_row(input int i, input vec_t t);
    chk($sformatf("row%0d id_valid", i), {31'd0, id_valid}, {31'd0, t.v});
    chk($sformatf("row%0d id_ready", i), {31'd0, id_ready}, {31'd0, t.r});
    chk($sformatf("row%0d id_state", i), {30'd0, id_state}, {30'd0, t.st});
    chk($sformatf("row%0d imm_sel", i), {29'd0, imm_sel}, {29'd0, t.imm});
    chk($sformatf("row%0d rs1_used", i), {31'd0, rs1_used}, {31'd0, t.r1u});
    chk($sformatf("row%0d rs2_used", i), {31'd0, rs2_used}, {31'd0, t.r2u});
    chk($sformatf("row%0d id_illegal", i), {31'd0, id_illegal}, {31'd0, t.ill});
    chk($sformatf("row%0d stall_cnt", i), {30'd0, stall_cnt}, {30'd0, t.cnt});
    chk($sformatf("row%0d id_instr", i), id_instr, t.ei);
    chk($sformatf("row%0d id_pc", i), id_pc, t.ep);
  endtask

  initial begin
    //   iv  instr  pc            er exv exl rd     fl | v  r  st  imm r1u r2u ill cnt  instr  pc
    add(0, 32'd0, 32'd0,        1, 0, 0, 5'd0, 0,  0, 1, 2'd0, 3'd0, 0, 0, 0, 2'd0, 32'd0, 32'd0);       // reset state
    add(1, I_A,   32'h100,      1, 0, 0, 5'd0, 0,  0, 1, 2'd0, 3'd0, 0, 0, 0, 2'd0, 32'd0, 32'd0);
    add(1, I_B,   32'h104,      1, 0, 0, 5'd0, 0,  1, 1, 2'd1, 3'd1, 1, 0, 0, 2'd0, I_A, 32'h100);
    add(0, 32'd0, 32'd0,        1, 0, 0, 5'd0, 0,  1, 1, 2'd1, 3'd2, 1, 1, 0, 2'd0, I_B, 32'h104);
    add(1, I_C,   32'h108,      1, 0, 0, 5'd0, 0,  0, 1, 2'd0, 3'd2, 1, 1, 0, 2'd0, I_B, 32'h104);
    add(1, I_D,   32'h10C,      1, 1, 1, 5'd5, 0,  0, 0, 2'd1, 3'd0, 1, 1, 0, 2'd0, I_C, 32'h108);      // load-use
    add(1, I_D,   32'h10C,      1, 1, 0, 5'd5, 0,  1, 1, 2'd2, 3'd0, 1, 1, 0, 2'd1, I_C, 32'h108);
    add(0, 32'd0, 32'd0,        1, 1, 1, 5'd5, 0,  1, 1, 2'd1, 3'd4, 0, 0, 0, 2'd1, I_D, 32'h10C);      // lui: no hazard
    add(1, I_A,   32'h110,      1, 1, 1, 5'd5, 0,  0, 1, 2'd0, 3'd4, 0, 0, 0, 2'd1, I_D, 32'h10C);
    add(1, I_E,   32'h114,      0, 1, 1, 5'd0, 0,  1, 0, 2'd1, 3'd1, 1, 0, 0, 2'd1, I_A, 32'h110);      // rd x0, backpressure
    add(1, I_E,   32'h114,      0, 0, 0, 5'd0, 0,  1, 0, 2'd1, 3'd1, 1, 0, 0, 2'd1, I_A, 32'h110);
    add(1, I_E,   32'h114,      0, 1, 1, 5'd0, 0,  1, 0, 2'd1, 3'd1, 1, 0, 0, 2'd1, I_A, 32'h110);
    add(1, I_E,   32'h114,      1, 0, 0, 5'd0, 0,  1, 1, 2'd1, 3'd1, 1, 0, 0, 2'd1, I_A, 32'h110);      // handoff+capture
    add(1, I_F,   32'h118,      1, 0, 0, 5'd0, 1,  0, 0, 2'd1, 3'd5, 0, 0, 0, 2'd1, I_E, 32'h114);      // flush
    add(1, I_F,   32'h118,      1, 0, 0, 5'd0, 0,  0, 1, 2'd0, 3'd5, 0, 0, 0, 2'd1, I_E, 32'h114);
    add(1, I_G,   32'h11C,      1, 0, 0, 5'd0, 0,  1, 1, 2'd1, 3'd4, 0, 0, 0, 2'd1, I_F, 32'h118);
    add(1, I_H,   32'h120,      1, 0, 0, 5'd0, 0,  1, 1, 2'd1, 3'd3, 1, 1, 0, 2'd1, I_G, 32'h11C);
    add(0, 32'd0, 32'd0,        0, 0, 0, 5'd0, 0,  1, 0, 2'd1, 3'd0, 0, 0, 1, 2'd1, I_H, 32'h120);      // illegal
    add(1, I_C,   32'h124,      1, 0, 0, 5'd0, 0,  1, 1, 2'd1, 3'd0, 0, 0, 1, 2'd1, I_H, 32'h120);
    add(0, 32'd0, 32'd0,        1, 1, 1, 5'd7, 0,  0, 0, 2'd1, 3'd0, 1, 1, 0, 2'd1, I_C, 32'h124);      // rs2 hazard
    add(0, 32'd0, 32'd0,        1, 1, 1, 5'd7, 0,  0, 0, 2'd2, 3'd0, 1, 1, 0, 2'd2, I_C, 32'h124);
    add(0, 32'd0, 32'd0,        1, 1, 1, 5'd7, 0,  0, 0, 2'd2, 3'd0, 1, 1, 0, 2'd3, I_C, 32'h124);
    add(0, 32'd0, 32'd0,        1, 1, 1, 5'd7, 0,  0, 0, 2'd2, 3'd0, 1, 1, 0, 2'd3, I_C, 32'h124);      // saturated
    add(0, 32'd0, 32'd0,        1, 1, 1, 5'd7, 1,  0, 0, 2'd2, 3'd0, 1, 1, 0, 2'd3, I_C, 32'h124);      // flush in stall
    add(0, 32'd0, 32'd0,        1, 0, 0, 5'd0, 0,  0, 1, 2'd0, 3'd0, 1, 1, 0, 2'd3, I_C, 32'h124);

    reset = 1'b1;
    if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0; ex_ready = 1'b1;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #2;
      check_row(i, vecs[i]);
      @(negedge clk);
    end

    // Mid-operation reset beats flush and a pending capture.
    if_valid = 1'b1; if_instr = I_A; if_pc = 32'h200; ex_ready = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; flush = 1'b0;
    @(negedge clk);
    if_valid = 1'b0;
    #2;
    chk("held id_valid", {31'd0, id_valid}, 32'd1);
    chk("held id_ready", {31'd0, id_ready}, 32'd0);
    chk("held id_instr", id_instr, I_A);
    chk("held rs1_addr", {27'd0, rs1_addr}, 32'd0);
    chk("held rs2_addr", {27'd0, rs2_addr}, 32'd5);
    @(negedge clk);
    reset = 1'b1; flush = 1'b1; if_valid = 1'b1; if_instr = I_B; if_pc = 32'h204; ex_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; if_valid = 1'b0;
    #2;
    chk("rst id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst id_ready", {31'd0, id_ready}, 32'd1);
    chk("rst id_state", {30'd0, id_state}, 32'd0);
    chk("rst id_instr", id_instr, 32'd0);
    chk("rst id_pc", id_pc, 32'd0);
    chk("rst stall_cnt", {30'd0, stall_cnt}, 32'd0);
    chk("rst imm_sel", {29'd0, imm_sel}, 32'd0);
    chk("rst id_illegal", {31'd0, id_illegal}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
